// File: rtl/fir_sym_folded_if.sv
// Sample/coefficient/output bundle of fir_sym_folded.
// master = sample source and coefficient writer, slave = the filter.
interface fir_sym_folded_if #(
  parameter int DIN_W  = 10,
  parameter int COEF_W = 6,
  parameter int DOUT_W = 12,
  parameter int AW     = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DIN_W-1:0]  in_data;
  logic                     coef_we;
  logic [AW-1:0]            coef_addr;
  logic signed [COEF_W-1:0] coef_wdata;
  logic                     out_valid;
  logic signed [DOUT_W-1:0] out_data;
  logic                     out_sat;
  logic                     busy;

  modport master (
    output in_valid, in_data, coef_we, coef_addr, coef_wdata,
    input  in_ready, out_valid, out_data, out_sat, busy
  );

  modport slave (
    input  in_valid, in_data, coef_we, coef_addr, coef_wdata,
    output in_ready, out_valid, out_data, out_sat, busy
  );
endinterface

// File: rtl/fir_sym_folded.sv
// Folded symmetric FIR: one pre-adder + one multiplier, one unique coefficient per cycle.
// Define FIR_SAT_EN for a saturating output stage; otherwise the output wraps.
module fir_sym_folded #(
  parameter int DIN_W  = 10,
  parameter int COEF_W = 6,
  parameter int DOUT_W = 12,
  parameter int TAPS   = 21,
  parameter int SHIFT  = 1,
  // packed with index 0 (outer tap) in the LSBs
  parameter logic [((TAPS+1)/2)*COEF_W-1:0] COEF_INIT =
    {6'h15, 6'h12, 6'h0A, 6'h01, 6'h3C, 6'h3C, 6'h3F, 6'h02, 6'h03, 6'h01, 6'h3F}
) (
  input  logic            clk,
  input  logic            rst,
  fir_sym_folded_if.slave bus
);
  localparam int NH    = (TAPS + 1) / 2;
  localparam int KW    = $clog2(NH);
  localparam int TW    = $clog2(TAPS);
  localparam int PW    = DIN_W + 1 + COEF_W;
  localparam int ACC_W = PW + KW;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_e;

  state_e                   state_q;
  logic signed [DIN_W-1:0]  x_q [TAPS];
  logic signed [COEF_W-1:0] c_q [NH];
  logic signed [ACC_W-1:0]  acc_q;
  logic [KW-1:0]            k_q;
  logic                     out_valid_q;
  logic                     out_sat_q;
  logic signed [DOUT_W-1:0] out_data_q;

  logic                     last_k;
  logic                     coef_ok;
  logic [TW-1:0]            mir_idx;
  logic signed [DIN_W:0]    xa, xb, pre;
  logic signed [PW-1:0]     prod;
  logic signed [DOUT_W-1:0] dout_d;
  logic                     sat_d;

  assign last_k  = (k_q == KW'(NH - 1));
  assign mir_idx = TW'(TAPS - 1) - TW'(k_q);
  assign xa      = (DIN_W+1)'(x_q[TW'(k_q)]);
  assign xb      = (DIN_W+1)'(x_q[mir_idx]);
  // centre tap has no mirror partner
  assign pre     = last_k ? xa : xa + xb;
  assign prod    = pre * c_q[k_q];

  assign coef_ok = bus.coef_we && (state_q == IDLE) &&
                   ({1'b0, bus.coef_addr} < (KW+1)'(NH));

`ifdef FIR_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DOUT_W+1){1'b0}}, {(DOUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DOUT_W+1){1'b1}}, {(DOUT_W-1){1'b0}}};
  logic signed [ACC_W-1:0] r;

  assign r = acc_q >>> SHIFT;

  always_comb begin
    dout_d = DOUT_W'(r);
    sat_d  = 1'b0;
    if (r > SAT_MAX) begin
      dout_d = {1'b0, {(DOUT_W-1){1'b1}}};
      sat_d  = 1'b1;
    end else if (r < SAT_MIN) begin
      dout_d = {1'b1, {(DOUT_W-1){1'b0}}};
      sat_d  = 1'b1;
    end
  end
`else
  assign dout_d = DOUT_W'(acc_q >>> SHIFT);
  assign sat_d  = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      k_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      for (int i = 0; i < TAPS; i++) x_q[i] <= '0;
      for (int i = 0; i < NH; i++)   c_q[i] <= COEF_INIT[i*COEF_W +: COEF_W];
    end else begin
      out_valid_q <= 1'b0;
      if (coef_ok) c_q[bus.coef_addr] <= bus.coef_wdata;
      case (state_q)
        IDLE: if (bus.in_valid) begin
          for (int i = TAPS - 1; i > 0; i--) x_q[i] <= x_q[i-1];
          x_q[0]  <= bus.in_data;
          acc_q   <= '0;
          k_q     <= '0;
          state_q <= MAC;
        end
        MAC: begin
          acc_q <= acc_q + ACC_W'(prod);
          k_q   <= k_q + KW'(1);
          if (last_k) state_q <= OUT;
        end
        OUT: begin
          out_valid_q <= 1'b1;
          out_data_q  <= dout_d;
          out_sat_q   <= sat_d;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;
endmodule

// File: tb/tb_fir_sym_folded.sv
// Scoreboard bench for fir_sym_folded: driver pushes expectations, monitor pops on out_valid.
module tb_fir_sym_folded;
  localparam int TAPS = 21;
  localparam int NH   = 11;

  typedef struct {
    int d;
    int s;
    int acyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  exp_t exp_q[$];
  int   hist[TAPS];
  int   cm[NH];
  int   init_c[NH] = '{-1, 1, 3, 2, -1, -4, -4, 1, 10, 18, 21};
  int   imp_tab[21] = '{-1, 0, 1, 1, -1, -2, -2, 0, 5, 9, 10, 9, 5, 0, -2, -2, -1, 1, 1, 0, -1};
  int   cw_tab[21]  = '{-1, 1, 3, 2, -1, -4, -4, 1, 10, 18, -5, 18, 10, 1, -4, -4, -1, 2, 3, 1, -1};

  fir_sym_folded_if #(.DIN_W(10), .COEF_W(6), .DOUT_W(12), .AW(4)) bus ();

  fir_sym_folded dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < TAPS; i++) hist[i] = 0;
    for (int i = 0; i < NH; i++) cm[i] = init_c[i];
  endfunction

  function automatic void out_of(input int r, output int d, output int s);
`ifdef FIR_SAT_EN
    if (r > 2047) begin d = 2047; s = 1; end
    else if (r < -2048) begin d = -2048; s = 1; end
    else begin d = r; s = 0; end
`else
    logic signed [11:0] t;
    t = 12'(r);
    d = t;
    s = 0;
`endif
  endfunction

  // direct-form reference: full 21-tap convolution over the sample history
  function automatic void push_exp(input int v, input bit hand, input int hd, input int hs);
    exp_t e;
    int   acc;
    for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = v;
    acc = 0;
    for (int j = 0; j < TAPS; j++) acc += hist[j] * cm[(j < NH) ? j : TAPS - 1 - j];
    out_of(acc >>> 1, e.d, e.s);
    if (hand) begin e.d = hd; e.s = hs; end
    e.acyc = cyc;
    exp_q.push_back(e);
  endfunction

  task automatic send(input int v, input bit push, input bit hand, input int hd, input int hs);
    int n;
    n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 10'(v);
    while (!bus.in_ready && n < 64) begin @(negedge clk); n++; end
    if (n >= 64) begin
      chk("accept_timeout", 0, 1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    if (push) push_exp(v, hand, hd, hs);
  endtask

  task automatic write_coef(input int a, input int d);
    @(negedge clk);
    bus.coef_we    = 1'b1;
    bus.coef_addr  = 4'(a);
    bus.coef_wdata = 6'(d);
    @(negedge clk);
    bus.coef_we = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("drain_timeout", exp_q.size(), 0);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // monitor
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (exp_q.size() == 0) chk("unexpected_out_valid", 1, 0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_data", bus.out_data, e.d);
        chk("out_sat", int'(bus.out_sat), e.s);
        chk("latency", cyc - e.acyc, 12);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int last;
    int t;
    bus.in_valid = 1'b0; bus.in_data = '0;
    bus.coef_we = 1'b0; bus.coef_addr = '0; bus.coef_wdata = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_busy", int'(bus.busy), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", int'(bus.in_ready), 1);

    // impulse response with default coefficients
    for (int i = 0; i < 21; i++) send(i == 0 ? 1 : 0, 1'b1, 1'b1, imp_tab[i], 0);
    drain();

    // throughput: in_valid held with a ramp
    do_reset();
    @(negedge clk);
    bus.in_valid = 1'b1;
    last = 0;
    for (int n = 0; n < 14; n++) begin
      bus.in_data = 10'(n + 1);
      t = 0;
      while (!bus.in_ready && t < 64) begin @(negedge clk); t++; end
      if (t >= 64) begin chk("ramp_accept_timeout", 0, 1); break; end
      @(posedge clk); #1;
      if (n > 0) chk("accept_period", cyc - last, 13);
      last = cyc;
      push_exp(n + 1, 1'b0, 0, 0);
    end
    bus.in_valid = 1'b0;
    drain();

    // DC overflow: steady r = 3550
    do_reset();
    for (int i = 0; i < 25; i++)
`ifdef FIR_SAT_EN
      send(100, 1'b1, i >= 20, 2047, 1);
`else
      send(100, 1'b1, i >= 20, -546, 0);
`endif
    drain();

    // negative full scale: r = -18176
    do_reset();
    for (int i = 0; i < 22; i++)
`ifdef FIR_SAT_EN
      send(-512, 1'b1, i >= 20, -2048, 1);
`else
      send(-512, 1'b1, i >= 20, -1792, 0);
`endif
    drain();

    // coefficient writes: idle write lands, out-of-range and busy writes drop
    do_reset();
    write_coef(10, -5);
    cm[10] = -5;
    write_coef(12, 9);
    send(2, 1'b1, 1'b1, cw_tab[0], 0);
    chk("busy_during_mac", int'(bus.busy), 1);
    write_coef(3, 9);
    for (int i = 1; i < 21; i++) send(0, 1'b1, 1'b1, cw_tab[i], 0);
    drain();

    // reset in the middle of a MAC
    write_coef(0, 7);
    send(1, 1'b0, 1'b0, 0, 0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midmac_out_data", bus.out_data, 0);
    chk("midmac_out_valid", int'(bus.out_valid), 0);
    chk("midmac_busy", int'(bus.busy), 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 21; i++) send(i == 0 ? 1 : 0, 1'b1, 1'b1, imp_tab[i], 0);
    drain();

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
